clk_div_gen: RTL and testbench

CLK_DIV_GEN -- requirements
Module: clk_div_gen

---
 rtl/clk_div_pkg.sv | 15 +
 rtl/clk_div_gen_if.sv | 27 ++
 rtl/clk_div_stage.sv | 104 ++++++++++
 rtl/clk_div_gen.sv | 89 ++++++++
 tb/tb_clk_div_gen.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants and the per-cycle action code used by the bclk and lrclk stages.
package clk_div_pkg;

  localparam int unsigned N_MIN = 32'd2;
  localparam int unsigned F_MIN = 32'd1;

  // What the period counter does at the coming clock edge.
  typedef enum logic [1:0] {
    ACT_IDLE = 2'd0,
    ACT_LOAD = 2'd1,
    ACT_RUN  = 2'd2,
    ACT_WRAP = 2'd3
  } act_e;

endpackage

// File: rtl/clk_div_gen_if.sv
// Control and clock-output bundle of the bclk/lrclk generator.
interface clk_div_gen_if #(
  parameter int DIV_W = 8,
  parameter int FRM_W = 6
);

  logic             en;
  logic             sync_restart;
  logic [DIV_W-1:0] bclk_div;
  logic [FRM_W-1:0] frame_len;
  logic             bclk;
  logic             bclk_rise;
  logic             bclk_fall;
  logic             lrclk;
  logic             frame_start;

  modport master (
    output en, sync_restart, bclk_div, frame_len,
    input  bclk, bclk_rise, bclk_fall, lrclk, frame_start
  );

  modport slave (
    input  en, sync_restart, bclk_div, frame_len,
    output bclk, bclk_rise, bclk_fall, lrclk, frame_start
  );

endinterface

// File: rtl/clk_div_stage.sv
// Bit-clock stage: period counter, active divisor register and registered bclk edge strobes.
module clk_div_stage
  import clk_div_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_restart,
  input  logic [DIV_W-1:0] i_div,
  output act_e             o_act,
  output logic             o_bclk,
  output logic             o_rise,
  output logic             o_fall
);

  logic             r_run;
  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_n;
  logic             r_bclk;
  logic             r_rise;
  logic             r_fall;

  act_e             w_act;
  logic [DIV_W-1:0] w_n_eff;
  logic [DIV_W-1:0] w_l;
  logic [DIV_W-1:0] w_cnt_nxt;

  assign w_n_eff   = (i_div < DIV_W'(N_MIN)) ? DIV_W'(N_MIN) : i_div;
  assign w_l       = r_n - (r_n >> 1);
  assign w_cnt_nxt = r_cnt + DIV_W'(1);

  // Restart outranks a wrap; an idle-to-running transition is treated as a restart.
  always_comb begin
    w_act = ACT_IDLE;
    if (!i_en) begin
      w_act = ACT_IDLE;
    end else if (i_restart || !r_run) begin
      w_act = ACT_LOAD;
    end else if (r_cnt == (r_n - DIV_W'(1))) begin
      w_act = ACT_WRAP;
    end else begin
      w_act = ACT_RUN;
    end
  end

  // Counter, active divisor and bclk/strobe registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run  <= 1'b0;
      r_cnt  <= '0;
      r_n    <= '0;
      r_bclk <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      case (w_act)
        ACT_IDLE: begin
          r_run  <= 1'b0;
          r_cnt  <= '0;
          r_bclk <= 1'b0;
          r_rise <= 1'b0;
          r_fall <= 1'b0;
        end
        ACT_LOAD: begin
          r_run  <= 1'b1;
          r_cnt  <= '0;
          r_n    <= w_n_eff;
          r_bclk <= 1'b0;
          r_rise <= 1'b0;
          r_fall <= r_bclk;
        end
        ACT_WRAP: begin
          r_run  <= 1'b1;
          r_cnt  <= '0;
          r_n    <= w_n_eff;
          r_bclk <= 1'b0;
          r_rise <= 1'b0;
          r_fall <= 1'b1;
        end
        ACT_RUN: begin
          r_cnt  <= w_cnt_nxt;
          r_bclk <= (w_cnt_nxt >= w_l);
          r_rise <= (w_cnt_nxt == w_l);
          r_fall <= 1'b0;
        end
        default: begin
          r_run  <= 1'b0;
          r_cnt  <= '0;
          r_bclk <= 1'b0;
          r_rise <= 1'b0;
          r_fall <= 1'b0;
        end
      endcase
    end
  end

  assign o_act  = w_act;
  assign o_bclk = r_bclk;
  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/clk_div_gen.sv
// Bit clock and frame clock generator; lrclk toggles after every F bclk periods.
module clk_div_gen
  import clk_div_pkg::*;
#(
  parameter int DIV_W = 8,
  parameter int FRM_W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  clk_div_gen_if.slave bus
);

  act_e             w_act;
  logic             w_bclk;
  logic             w_rise;
  logic             w_fall;
  logic [FRM_W-1:0] w_f_eff;
  logic [FRM_W-1:0] w_pcnt_nxt;

  logic [FRM_W-1:0] r_f;
  logic [FRM_W-1:0] r_pcnt;
  logic             r_lrclk;
  logic             r_fs;

  clk_div_stage #(.DIV_W(DIV_W)) u_stage (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_en      (bus.en),
    .i_restart (bus.sync_restart),
    .i_div     (bus.bclk_div),
    .o_act     (w_act),
    .o_bclk    (w_bclk),
    .o_rise    (w_rise),
    .o_fall    (w_fall)
  );

  assign w_f_eff    = (bus.frame_len < FRM_W'(F_MIN)) ? FRM_W'(F_MIN) : bus.frame_len;
  assign w_pcnt_nxt = r_pcnt + FRM_W'(1);

  // Frame stage: counts bclk wraps, toggling lrclk on the same edge as the bclk fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_f     <= '0;
      r_pcnt  <= '0;
      r_lrclk <= 1'b0;
      r_fs    <= 1'b0;
    end else begin
      case (w_act)
        ACT_IDLE: begin
          r_pcnt  <= '0;
          r_lrclk <= 1'b0;
          r_fs    <= 1'b0;
        end
        ACT_LOAD: begin
          r_f     <= w_f_eff;
          r_pcnt  <= '0;
          r_lrclk <= 1'b0;
          r_fs    <= r_lrclk;
        end
        ACT_WRAP: begin
          r_f <= w_f_eff;
          if (w_pcnt_nxt == r_f) begin
            r_pcnt  <= '0;
            r_lrclk <= ~r_lrclk;
            r_fs    <= r_lrclk;
          end else begin
            r_pcnt  <= w_pcnt_nxt;
            r_fs    <= 1'b0;
          end
        end
        ACT_RUN: begin
          r_fs <= 1'b0;
        end
        default: begin
          r_pcnt  <= '0;
          r_lrclk <= 1'b0;
          r_fs    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.bclk        = w_bclk;
  assign bus.bclk_rise   = w_rise;
  assign bus.bclk_fall   = w_fall;
  assign bus.lrclk       = r_lrclk;
  assign bus.frame_start = r_fs;

endmodule

// File: tb/tb_clk_div_gen.sv
// Directed bench for clk_div_gen; outputs are packed as {bclk, bclk_rise, bclk_fall, lrclk, frame_start}.
module tb_clk_div_gen;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  clk_div_gen_if #(.DIV_W(8), .FRM_W(6)) bus ();

  clk_div_gen #(.DIV_W(8), .FRM_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drop en for one edge, load settings, raise en; the next edge is the start edge.
  task automatic arm(input logic [7:0] div, input logic [5:0] flen);
    bus.en = 1'b0;
    bus.sync_restart = 1'b0;
    step();
    bus.bclk_div  = div;
    bus.frame_len = flen;
    bus.en        = 1'b1;
  endtask

  task automatic test_reset();
    logic [4:0] obs;
    rst_n = 1'b0;
    bus.en = 1'b1;
    bus.sync_restart = 1'b0;
    bus.bclk_div = 8'd4;
    bus.frame_len = 6'd2;
    step();
    step();
    obs = {bus.bclk, bus.bclk_rise, bus.bclk_fall, bus.lrclk, bus.frame_start};
    checks++;
    if (obs !== 5'b00000) begin
      $display("FAIL reset got=%b exp=%b", obs, 5'b00000);
      errors++;
    end
    bus.en = 1'b0;
    rst_n = 1'b1;
    step();
    obs = {bus.bclk, bus.bclk_rise, bus.bclk_fall, bus.lrclk, bus.frame_start};
    checks++;
    if (obs !== 5'b00000) begin
      $display("FAIL idle_after_reset got=%b exp=%b", obs, 5'b00000);
      errors++;
    end
  endtask

  // N=4, F=2: bclk 0011, rise at cnt 2, lrclk toggles every 8 clk, frame_start every 16.
  task automatic test_basic(input string tag, input int ncyc);
    logic [4:0] obs, exp;
    int cnt;
    for (int c = 1; c <= ncyc; c++) begin
      step();
      cnt = (c - 1) % 4;
      exp[4] = (cnt >= 2);
      exp[3] = (cnt == 2);
      exp[2] = (cnt == 0) && (c > 1);
      exp[1] = (((c - 1) / 8) % 2) == 1;
      exp[0] = ((c - 1) % 16 == 0) && (c > 1);
      obs = {bus.bclk, bus.bclk_rise, bus.bclk_fall, bus.lrclk, bus.frame_start};
      checks++;
      if (obs !== exp) begin
        $display("FAIL %s c=%0d got=%b exp=%b", tag, c, obs, exp);
        errors++;
      end
    end
  endtask

  // Odd N=5 (3 low, 2 high) and divisors 0/1 clamped to 2 (0101...).
  task automatic test_odd_and_min();
    logic [4:0] obs, exp;
    logic [7:0] divs [3];
    int n, l, cnt;
    divs[0] = 8'd5;
    divs[1] = 8'd0;
    divs[2] = 8'd1;
    for (int k = 0; k < 3; k++) begin
      arm(divs[k], 6'd63);
      n = (k == 0) ? 5 : 2;
      l = (k == 0) ? 3 : 1;
      for (int c = 1; c <= 12; c++) begin
        step();
        cnt = (c - 1) % n;
        exp = {(cnt >= l), (cnt == l), ((cnt == 0) && (c > 1)), 1'b0, 1'b0};
        obs = {bus.bclk, bus.bclk_rise, bus.bclk_fall, bus.lrclk, bus.frame_start};
        checks++;
        if (obs !== exp) begin
          $display("FAIL div%0d c=%0d got=%b exp=%b", divs[k], c, obs, exp);
          errors++;
        end
      end
    end
  endtask

  // Divisor raised 4->6 at cnt=1: current period stays 4, following periods are 6.
  task automatic test_div_change();
    logic [4:0] obs, exp;
    int cnt;
    arm(8'd4, 6'd63);
    for (int c = 1; c <= 18; c++) begin
      step();
      if (c == 2) bus.bclk_div = 8'd6;
      if (c <= 4) begin
        cnt = c - 1;
        exp = {(cnt >= 2), (cnt == 2), 1'b0, 1'b0, 1'b0};
      end else begin
        cnt = (c - 5) % 6;
        exp = {(cnt >= 3), (cnt == 3), (cnt == 0), 1'b0, 1'b0};
      end
      obs = {bus.bclk, bus.bclk_rise, bus.bclk_fall, bus.lrclk, bus.frame_start};
      checks++;
      if (obs !== exp) begin
        $display("FAIL div_change c=%0d got=%b exp=%b", c, obs, exp);
        errors++;
      end
    end
  endtask

  // N=4, F=1: restart while bclk=1/lrclk=1, then restart colliding with a wrap.
  task automatic test_restart();
    logic [4:0] obs, exp;
    int cnt, lim;
    arm(8'd4, 6'd1);
    for (int pass = 0; pass < 3; pass++) begin
      lim = (pass == 0) ? 7 : ((pass == 1) ? 4 : 10);
      for (int c = (pass == 0) ? 1 : 2; c <= lim; c++) begin
        step();
        cnt = (c - 1) % 4;
        exp[4] = (cnt >= 2);
        exp[3] = (cnt == 2);
        exp[2] = (cnt == 0) && (c > 1);
        exp[1] = (((c - 1) / 4) % 2) == 1;
        exp[0] = ((c - 1) % 8 == 0) && (c > 1);
        obs = {bus.bclk, bus.bclk_rise, bus.bclk_fall, bus.lrclk, bus.frame_start};
        checks++;
        if (obs !== exp) begin
          $display("FAIL restart p%0d c=%0d got=%b exp=%b", pass, c, obs, exp);
          errors++;
        end
      end
      if (pass < 2) begin
        bus.sync_restart = 1'b1;
        step();
        bus.sync_restart = 1'b0;
        exp = (pass == 0) ? 5'b00101 : 5'b00100;
        obs = {bus.bclk, bus.bclk_rise, bus.bclk_fall, bus.lrclk, bus.frame_start};
        checks++;
        if (obs !== exp) begin
          $display("FAIL restart_edge p%0d got=%b exp=%b", pass, obs, exp);
          errors++;
        end
      end
    end
  endtask

  // en dropped mid-high phase (restart ignored while off), then a clean start.
  task automatic test_en_drop();
    logic [4:0] obs, exp;
    int cnt;
    arm(8'd4, 6'd63);
    for (int c = 1; c <= 3; c++) step();
    bus.en = 1'b0;
    bus.sync_restart = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      obs = {bus.bclk, bus.bclk_rise, bus.bclk_fall, bus.lrclk, bus.frame_start};
      checks++;
      if (obs !== 5'b00000) begin
        $display("FAIL en_drop k=%0d got=%b exp=%b", k, obs, 5'b00000);
        errors++;
      end
    end
    bus.sync_restart = 1'b0;
    bus.en = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      step();
      cnt = (c - 1) % 4;
      exp = {(cnt >= 2), (cnt == 2), ((cnt == 0) && (c > 1)), 1'b0, 1'b0};
      obs = {bus.bclk, bus.bclk_rise, bus.bclk_fall, bus.lrclk, bus.frame_start};
      checks++;
      if (obs !== exp) begin
        $display("FAIL en_restart c=%0d got=%b exp=%b", c, obs, exp);
        errors++;
      end
    end
  endtask

  // Asynchronous reset mid-period, then the N=4/F=2 sequence from scratch.
  task automatic test_async_reset();
    logic [4:0] obs;
    arm(8'd4, 6'd2);
    for (int c = 1; c <= 11; c++) step();
    #2;
    rst_n = 1'b0;
    #1;
    obs = {bus.bclk, bus.bclk_rise, bus.bclk_fall, bus.lrclk, bus.frame_start};
    checks++;
    if (obs !== 5'b00000) begin
      $display("FAIL async_reset got=%b exp=%b", obs, 5'b00000);
      errors++;
    end
    step();
    step();
    rst_n = 1'b1;
    test_basic("after_reset", 34);
  endtask

  initial begin
    bus.en = 1'b0;
    bus.sync_restart = 1'b0;
    bus.bclk_div = 8'd0;
    bus.frame_len = 6'd0;
    test_reset();
    arm(8'd4, 6'd2);
    test_basic("basic", 34);
    test_odd_and_min();
    test_div_change();
    test_restart();
    test_en_drop();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
